// File: rtl/riscv_pio_pkg.sv
// Shared definitions for the PIO peripherals: register word map, edge and irq mode
// encodings, and the Avalon write-strobe decode used by every PIO register.
package riscv_pio_pkg;

  typedef enum logic [1:0] {
    PIO_ADDR_DATA = 2'd0,
    PIO_ADDR_DIR  = 2'd1,
    PIO_ADDR_MASK = 2'd2,
    PIO_ADDR_EDGE = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int IRQ_EDGE  = 0;
  localparam int IRQ_LEVEL = 1;

  function automatic logic pio_wr_hit(input logic      cs,
                                      input logic      wr_n,
                                      input logic [1:0] addr,
                                      input pio_addr_e sel);
    return cs && !wr_n && (addr == sel);
  endfunction

endpackage

// File: rtl/riscv_pio_sync_edge.sv
// Two-flop synchroniser for the external input bus followed by a history register,
// producing the synchronised data and the per-bit edge vector for the chosen edge type.
module riscv_pio_sync_edge
  import riscv_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] edge_vec
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] prev_p2;

  // p0/p1: metastability chain, p2: previous synchronised value for edge compare
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      prev_p2 <= '0;
    end else begin
      sync_p0 <= in_port;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign data = sync_p1;

  if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
    assign edge_vec = ~sync_p1 & prev_p2;
  end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
    assign edge_vec = sync_p1 ^ prev_p2;
  end else begin : g_rise
    assign edge_vec = sync_p1 & ~prev_p2;
  end

endmodule

// File: rtl/riscv_simulation_pio_in.sv
// Avalon-MM parallel input port: synchronised data read-back, interrupt mask,
// sticky write-1-to-clear edge capture and a maskable edge- or level-sourced irq.
module riscv_simulation_pio_in
  import riscv_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISING,
  parameter int IRQ_TYPE  = IRQ_EDGE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] clear_vec;
  logic             mask_wr;
  logic             edge_wr;
  logic [31:0]      data_ext;
  logic [31:0]      mask_ext;
  logic [31:0]      capture_ext;
  logic             unused_wdata;

  // Bits above WIDTH on the write bus carry no register content.
  assign unused_wdata = ^writedata;

  riscv_pio_sync_edge #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .data     (data_sync),
    .edge_vec (edge_vec)
  );

  assign mask_wr   = pio_wr_hit(chipselect, write_n, address, PIO_ADDR_MASK);
  assign edge_wr   = pio_wr_hit(chipselect, write_n, address, PIO_ADDR_EDGE);
  assign clear_vec = edge_wr ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (mask_wr) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // Edge is OR-ed after the clear so a same-cycle clear never drops a new edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clear_vec) | edge_vec;
    end
  end

  always_comb begin
    data_ext                 = '0;
    mask_ext                 = '0;
    capture_ext              = '0;
    data_ext[WIDTH-1:0]      = data_sync;
    mask_ext[WIDTH-1:0]      = irq_mask;
    capture_ext[WIDTH-1:0]   = edge_capture;
  end

  // Read mux ignores chipselect so the bus sees data with zero wait states.
  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA: readdata = data_ext;
      PIO_ADDR_DIR:  readdata = '0;
      PIO_ADDR_MASK: readdata = mask_ext;
      PIO_ADDR_EDGE: readdata = capture_ext;
      default:       readdata = '0;
    endcase
  end

  if (IRQ_TYPE == IRQ_LEVEL) begin : g_irq_level
    assign irq = |(data_sync & irq_mask);
  end else begin : g_irq_edge
    assign irq = |(edge_capture & irq_mask);
  end

endmodule
